bp_update_scheduler: RTL and testbench

- Sits between EX branch resolution and the shared predictor structures: branch_predictor update port and single-ported BTB.
- Buffers resolved control-flow records and drains them one per cycle when the BTB port is free.
- IF lookups have priority over drains. An anti-starvation counter forces a drain by stalling IF for one cycle.

---
 rtl/bp_update_scheduler_pkg.sv | 26 ++
 rtl/bp_update_fifo.sv | 73 +++++++
 rtl/bp_update_scheduler.sv | 164 ++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update path: the buffered resolution
// record, the scheduler state encoding and the BTB-write qualification rule.
package bp_update_scheduler_pkg;

    localparam int RV_XLEN = 32;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] target;
        logic               taken;
        logic               is_branch;
        logic               is_jump;
    } bp_update_t;

    typedef enum logic [1:0] {
        BPS_IDLE  = 2'd0,
        BPS_DRAIN = 2'd1,
        BPS_FORCE = 2'd2
    } bp_sched_state_e;

    // Only redirecting control flow is worth a BTB entry.
    function automatic logic needs_btb_write(input bp_update_t e);
        return e.is_jump || (e.is_branch && e.taken);
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO of resolved-branch records; head is visible combinationally.
// Storage is not reset, only the pointers and occupancy are.
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  bp_update_t             wdata_i,
    input  logic                   pop_i,
    output bp_update_t             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    bp_update_t        mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Buffers resolved branches/jumps and drains them in order to the predictor and
// BTB whenever IF leaves the BTB port idle; starvation forces a one-cycle IF stall.
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int XLEN         = RV_XLEN,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ex_valid,
    output logic                        ex_ready,
    input  logic [XLEN-1:0]             ex_pc,
    input  logic [XLEN-1:0]             ex_target,
    input  logic                        ex_taken,
    input  logic                        ex_is_branch,
    input  logic                        ex_is_jump,
    input  logic                        if_lookup_req,
    output logic                        if_stall,
    output logic                        bp_update_en,
    output logic [XLEN-1:0]             bp_update_pc,
    output logic                        bp_actual_taken,
    output logic [XLEN-1:0]             bp_actual_target,
    output logic                        bp_is_branch,
    output logic                        btb_we,
    output logic [XLEN-1:0]             btb_wpc,
    output logic [XLEN-1:0]             btb_wtarget,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    bp_sched_state_e state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;

    bp_update_t      ex_entry;
    bp_update_t      head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            push;
    logic            pop;
    logic            blocked;

    logic            bp_en_q;
    logic [XLEN-1:0] bp_pc_q;
    logic            bp_taken_q;
    logic [XLEN-1:0] bp_target_q;
    logic            bp_is_branch_q;
    logic            btb_we_q;
    logic [XLEN-1:0] btb_wpc_q;
    logic [XLEN-1:0] btb_wtarget_q;

    always_comb begin
        ex_entry           = '0;
        ex_entry.pc        = ex_pc;
        ex_entry.target    = ex_target;
        ex_entry.taken     = ex_taken;
        ex_entry.is_branch = ex_is_branch;
        ex_entry.is_jump   = ex_is_jump;
    end

    // Full means not ready, even if this cycle also pops.
    assign ex_ready  = !fifo_full;
    assign push      = ex_valid && ex_ready && (ex_is_branch || ex_is_jump);
    assign pop       = !fifo_empty && (!if_lookup_req || state_q == BPS_FORCE);
    assign blocked   = !fifo_empty && if_lookup_req && state_q != BPS_FORCE;
    assign count_nxt = count + CW'(push) - CW'(pop);

    bp_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (ex_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (blocked && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
        case (state_q)
            BPS_IDLE: begin
                if (push) begin
                    state_d = BPS_DRAIN;
                end
            end
            BPS_DRAIN: begin
                if (starve_d == STARVE_MAX) begin
                    state_d = BPS_FORCE;
                end else if (count_nxt == '0) begin
                    state_d = BPS_IDLE;
                end
            end
            BPS_FORCE: begin
                state_d = (count_nxt != '0) ? BPS_DRAIN : BPS_IDLE;
            end
            default: state_d = BPS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BPS_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // The popped head becomes visible to the predictor and BTB one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_en_q        <= 1'b0;
            bp_pc_q        <= '0;
            bp_taken_q     <= 1'b0;
            bp_target_q    <= '0;
            bp_is_branch_q <= 1'b0;
            btb_we_q       <= 1'b0;
            btb_wpc_q      <= '0;
            btb_wtarget_q  <= '0;
        end else begin
            bp_en_q  <= pop;
            btb_we_q <= pop && needs_btb_write(head);
            if (pop) begin
                bp_pc_q        <= head.pc;
                bp_taken_q     <= head.taken;
                bp_target_q    <= head.target;
                bp_is_branch_q <= head.is_branch;
                if (needs_btb_write(head)) begin
                    btb_wpc_q     <= head.pc;
                    btb_wtarget_q <= head.target;
                end
            end
        end
    end

    assign if_stall         = (state_q == BPS_FORCE);
    assign fifo_count       = count;
    assign bp_update_en     = bp_en_q;
    assign bp_update_pc     = bp_pc_q;
    assign bp_actual_taken  = bp_taken_q;
    assign bp_actual_target = bp_target_q;
    assign bp_is_branch     = bp_is_branch_q;
    assign btb_we           = btb_we_q;
    assign btb_wpc          = btb_wpc_q;
    assign btb_wtarget      = btb_wtarget_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed scenarios then random traffic, all
// compared against a queue-based reference model.
module tb_bp_update_scheduler;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_taken;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic            if_lookup_req;
    logic            if_stall;
    logic            bp_update_en;
    logic [XLEN-1:0] bp_update_pc;
    logic            bp_actual_taken;
    logic [XLEN-1:0] bp_actual_target;
    logic            bp_is_branch;
    logic            btb_we;
    logic [XLEN-1:0] btb_wpc;
    logic [XLEN-1:0] btb_wtarget;
    logic [2:0]      fifo_count;

    always #5 clk = ~clk;

    bp_update_scheduler #(
        .XLEN         (XLEN),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_taken         (ex_taken),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .if_lookup_req    (if_lookup_req),
        .if_stall         (if_stall),
        .bp_update_en     (bp_update_en),
        .bp_update_pc     (bp_update_pc),
        .bp_actual_taken  (bp_actual_taken),
        .bp_actual_target (bp_actual_target),
        .bp_is_branch     (bp_is_branch),
        .btb_we           (btb_we),
        .btb_wpc          (btb_wpc),
        .btb_wtarget      (btb_wtarget),
        .fifo_count       (fifo_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic        br;
        logic        jp;
    } rec_t;

    rec_t        mq[$];
    bit          m_force;
    int          m_cnt;
    logic        m_en, m_tk, m_br, m_we;
    logic [31:0] m_upc, m_utgt, m_wpc, m_wtgt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_force = 0;
        m_cnt   = 0;
        m_en = 0; m_tk = 0; m_br = 0; m_we = 0;
        m_upc = 0; m_utgt = 0; m_wpc = 0; m_wtgt = 0;
    endtask

    // Reference: in-order queue, IF wins the port unless a forced cycle is due,
    // which happens right after LIMIT consecutive blocked cycles.
    task automatic model_step(input logic v, input rec_t r, input logic lk);
        int   sz;
        bit   rdy, pop, blocked, push;
        rec_t h;
        sz      = mq.size();
        rdy     = (sz != DEPTH);
        pop     = (sz > 0) && (!lk || m_force);
        blocked = (sz > 0) && lk && !m_force;
        push    = v && rdy && (r.br || r.jp);
        m_en = 0;
        m_we = 0;
        if (pop) begin
            h     = mq.pop_front();
            m_en  = 1;
            m_upc = h.pc; m_utgt = h.tgt; m_tk = h.tk; m_br = h.br;
            if (h.jp || (h.br && h.tk)) begin
                m_we = 1; m_wpc = h.pc; m_wtgt = h.tgt;
            end
        end
        if (push) mq.push_back(r);
        if (pop || sz == 0) m_cnt = 0;
        else if (blocked && m_cnt < LIMIT) m_cnt++;
        m_force = blocked && (m_cnt >= LIMIT);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ready"},  ex_ready, mq.size() != DEPTH);
        check({tag, "_stall"},  if_stall, m_force);
        check({tag, "_count"},  fifo_count, mq.size());
        check({tag, "_en"},     bp_update_en, m_en);
        check({tag, "_upc"},    bp_update_pc, m_upc);
        check({tag, "_utaken"}, bp_actual_taken, m_tk);
        check({tag, "_utgt"},   bp_actual_target, m_utgt);
        check({tag, "_ubr"},    bp_is_branch, m_br);
        check({tag, "_we"},     btb_we, m_we);
        check({tag, "_wpc"},    btb_wpc, m_wpc);
        check({tag, "_wtgt"},   btb_wtarget, m_wtgt);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic br, input logic jp, input logic lk);
        rec_t r;
        r.pc = pc; r.tgt = tgt; r.tk = tk; r.br = br; r.jp = jp;
        ex_valid = v; ex_pc = pc; ex_target = tgt;
        ex_taken = tk; ex_is_branch = br; ex_is_jump = jp;
        if_lookup_req = lk;
        #4;
        check_outputs("cyc");
        model_step(v, r, lk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic lk);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, lk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ex_valid = 0; ex_pc = 0; ex_target = 0; ex_taken = 0;
        ex_is_branch = 0; ex_is_jump = 0; if_lookup_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst");
        check("rst_ready_const", ex_ready, 1);
        reset = 1'b0;

        // Taken branch: popped next cycle, visible the cycle after.
        step(1, 32'h100, 32'h80, 1, 1, 0, 0);
        idle(0);
        check("t1_en", bp_update_en, 1);
        check("t1_we", btb_we, 1);
        check("t1_wpc", btb_wpc, 32'h100);
        check("t1_wtgt", btb_wtarget, 32'h80);
        check("t1_count", fifo_count, 0);

        // Not-taken branch updates the predictor but not the BTB.
        step(1, 32'h200, 32'h240, 0, 1, 0, 0);
        idle(0);
        check("t2_en", bp_update_en, 1);
        check("t2_taken", bp_actual_taken, 0);
        check("t2_we", btb_we, 0);
        check("t2_wpc_hold", btb_wpc, 32'h100);
        idle(0);

        // Starvation: IF hogs the port until a forced drain.
        for (int k = 0; k < 4; k++) step(1, 32'h400 + 4 * k, 32'h500, k[0], 1, 0, 1);
        check("t3_count_full", fifo_count, 4);
        check("t3_ready_full", ex_ready, 0);
        n = 0;
        while (!m_force && n < 20) begin
            idle(1);
            n++;
        end
        check("t3_wait_cycles", n, 5);
        check("t3_stall", if_stall, 1);
        check("t3_count_pre", fifo_count, 4);
        idle(1);
        check("t3_count_post", fifo_count, 3);
        check("t3_stall_post", if_stall, 0);
        check("t3_en", bp_update_en, 1);
        check("t3_pc", bp_update_pc, 32'h400);
        repeat (6) idle(0);

        // Full FIFO drained with ex_valid held: ordering and ex_ready timing.
        for (int k = 0; k < 4; k++) step(1, 32'h10 + 4 * k, 32'h900 + k, 1, 0, 1, 1);
        check("t4_ready_full", ex_ready, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 32'h40 + 4 * k, 32'h0, 0, 1, 0, 0);
            check("t4_order", bp_update_pc, 32'h10 + 4 * k);
            if (k == 0) check("t4_ready_rise", ex_ready, 1);
        end
        repeat (6) idle(0);

        // Non-control-flow record is accepted and dropped.
        step(1, 32'h300, 32'h310, 1, 0, 0, 0);
        check("t5_count", fifo_count, 0);
        idle(0);
        check("t5_en", bp_update_en, 0);

        // Asynchronous reset mid-drain.
        for (int k = 0; k < 3; k++) step(1, 32'h600 + 4 * k, 32'h700, 1, 1, 0, 1);
        ex_valid = 0;
        if_lookup_req = 0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_count", fifo_count, 0);
        check("t6_en", bp_update_en, 0);
        check("t6_we", btb_we, 0);
        check("t6_stall", if_stall, 0);
        check("t6_ready", ex_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        check("t6_en_after", bp_update_en, 0);
        check("t6_count_after", fifo_count, 0);
        reset = 1'b0;

        // Random traffic with IF mostly busy so forced drains occur.
        repeat (800) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 7));
        end
        repeat (8) idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
